// File: rtl/par_to_ser_tx.sv
// Byte-to-serial transmitter: start bit (0), 8 data bits MSB first, stop bit (1),
// each bit held for BIT_CYCLES clocks on a registered, idle-high line.
module par_to_ser_tx #(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] parout,
    input  logic       load,
    output logic       serout,
    output logic       busy,
    output logic       charSent,
    output logic [1:0] state_dbg
);

    // Handshake: load is a level request taken only in IDLE (busy=0); the byte on
    // parout is captured on that edge and busy rises the next cycle. A load held
    // through the charSent cycle starts the next frame immediately.
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shreg, shreg_d;
    logic        serout_d, busy_d, char_sent_d;
    logic        bit_end;

    assign bit_end   = (cnt == CW'(BIT_CYCLES - 1));
    assign state_dbg = state;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_idx_d   = bit_idx;
        shreg_d     = shreg;
        char_sent_d = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_d   = START;
                    shreg_d   = parout;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shreg_d   = {shreg[6:0], 1'b0};
                    bit_idx_d = bit_idx + 3'd1;
                    // Leave on the last index so the 3-bit wrap never restarts DATA.
                    if (bit_idx == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    char_sent_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state.
        serout_d = 1'b1;
        if (state_d == START)     serout_d = 1'b0;
        else if (state_d == DATA) serout_d = shreg_d[7];
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            serout   <= 1'b1;
            busy     <= 1'b0;
            charSent <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            serout   <= serout_d;
            busy     <= busy_d;
            charSent <= char_sent_d;
        end
    end

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Bench for par_to_ser_tx: BIT_CYCLES=4 and BIT_CYCLES=2 instances share stimulus,
// a frame-level model is compared every cycle, and directed frames are pinned to literals.
module tb_par_to_ser_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] parout = 8'h00;
    logic       so4, b4, cs4, so2, b2, cs2;
    logic [1:0] st4, st2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    par_to_ser_tx #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .parout(parout), .load(load),
        .serout(so4), .busy(b4), .charSent(cs4), .state_dbg(st4)
    );

    par_to_ser_tx #(.BIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .parout(parout), .load(load),
        .serout(so2), .busy(b2), .charSent(cs2), .state_dbg(st2)
    );

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: mt = cycles into the current frame (-1 when idle), md = captured byte.
    int         bcs[2] = '{4, 2};
    int         mt[2] = '{-1, -1};
    logic [7:0] md[2] = '{8'h00, 8'h00};
    logic       mcs[2] = '{1'b0, 1'b0};
    bit         mvalid[2] = '{1'b0, 1'b0};

    function automatic logic exp_bit(int t, int bc, logic [7:0] d);
        int idx;
        if (t < 0) return 1'b1;
        idx = t / bc;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[8 - idx];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mt[i] = -1;
                mcs[i] = 1'b0;
                mvalid[i] = 1'b1;
            end else if (mt[i] < 0) begin
                mcs[i] = 1'b0;
                if (load) begin
                    md[i] = parout;
                    mt[i] = 0;
                end
            end else begin
                mt[i]++;
                if (mt[i] == 10 * bcs[i]) begin
                    mt[i] = -1;
                    mcs[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mvalid[i]) begin
                chk($sformatf("model_serout_bc%0d", bcs[i]), (i == 0) ? so4 : so2,
                    exp_bit(mt[i], bcs[i], md[i]));
                chk($sformatf("model_busy_bc%0d", bcs[i]), (i == 0) ? b4 : b2, mt[i] >= 0);
                chk($sformatf("model_charsent_bc%0d", bcs[i]), (i == 0) ? cs4 : cs2, mcs[i]);
            end
        end
    end

    logic cap_so[2][0:99];
    logic cap_b[2][0:99];
    logic cap_cs[2][0:99];

    task automatic tick(int k);
        @(negedge clk);
        cap_so[0][k] = so4; cap_b[0][k] = b4; cap_cs[0][k] = cs4;
        cap_so[1][k] = so2; cap_b[1][k] = b2; cap_cs[1][k] = cs2;
    endtask

    task automatic check_frame(string name, logic [9:0] pat, int first, int bc, int inst);
        for (int k = 0; k < 10 * bc; k++) begin
            chk({name, "_serout"}, cap_so[inst][first + k], pat[9 - k / bc]);
            chk({name, "_busy"}, cap_b[inst][first + k], 1'b1);
        end
        chk({name, "_charsent_end"}, cap_cs[inst][first + 10 * bc], 1'b1);
        chk({name, "_busy_end"}, cap_b[inst][first + 10 * bc], 1'b0);
    endtask

    initial begin
        int n_cs;
        repeat (3) @(negedge clk);
        chk("reset_serout", so4, 1'b1);
        chk("reset_busy", b4, 1'b0);
        chk("reset_charsent", cs4, 1'b0);
        chk("reset_state", st4, 2'd0);
        chk("reset_serout_bc2", so2, 1'b1);
        chk("reset_state_bc2", st2, 2'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte A5
        parout = 8'hA5; load = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            tick(k);
            if (k == 1) load = 1'b0;
        end
        check_frame("a5", 10'b0101001011, 1, 4, 0);
        for (int k = 42; k <= 44; k++) chk("a5_single_pulse", cap_cs[0][k], 1'b0);

        // Load while busy must not disturb the frame or start another
        parout = 8'h0F; load = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick(k);
            if (k == 1) load = 1'b0;
            if (k == 10) begin parout = 8'hFF; load = 1'b1; end
            if (k == 11) load = 1'b0;
        end
        check_frame("0f", 10'b0000011111, 1, 4, 0);
        for (int k = 42; k <= 50; k++) chk("0f_no_second", cap_b[0][k], 1'b0);

        // Back-to-back with load held high
        parout = 8'h00; load = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            tick(k);
            if (k == 1) parout = 8'hFF;
            if (k == 42) load = 1'b0;
        end
        check_frame("b2b_00", 10'b0000000001, 1, 4, 0);
        check_frame("b2b_ff", 10'b0111111111, 42, 4, 0);
        n_cs = 0;
        for (int k = 1; k <= 90; k++) if (cap_cs[0][k] === 1'b1) n_cs++;
        chk("b2b_pulse_count", 8'(n_cs), 8'd2);

        // Reset mid-frame aborts without charSent
        parout = 8'h3C; load = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(k);
            if (k == 1) load = 1'b0;
            if (k == 17) reset = 1'b1;
            if (k == 18) reset = 1'b0;
        end
        chk("abort_busy_before", cap_b[0][17], 1'b1);
        for (int k = 18; k <= 30; k++) begin
            chk("abort_serout", cap_so[0][k], 1'b1);
            chk("abort_busy", cap_b[0][k], 1'b0);
            chk("abort_charsent", cap_cs[0][k], 1'b0);
        end
        parout = 8'h81; load = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            tick(k);
            if (k == 1) load = 1'b0;
        end
        check_frame("after_abort_81", 10'b0100000011, 1, 4, 0);

        // Reset wins over load in the same cycle
        reset = 1'b1; load = 1'b1; parout = 8'h55;
        tick(1);
        reset = 1'b0; load = 1'b0;
        for (int k = 2; k <= 6; k++) tick(k);
        for (int k = 1; k <= 6; k++) begin
            chk("rst_load_busy", cap_b[0][k], 1'b0);
            chk("rst_load_serout", cap_so[0][k], 1'b1);
            chk("rst_load_busy_bc2", cap_b[1][k], 1'b0);
        end

        // BIT_CYCLES=2 corner with 80
        parout = 8'h80; load = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick(k);
            if (k == 1) load = 1'b0;
        end
        check_frame("bc2_80", 10'b0100000001, 1, 2, 1);
        check_frame("bc4_80", 10'b0100000001, 1, 4, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/par_to_ser_tx.md
PAR_TO_SER_TX -- requirements
Module: par_to_ser_tx

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 16, meaning clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port parout  input  8  byte to transmit, sampled only on an accepted load.
REQ-005 SHALL have port load  input  1  request to send parout; level-sampled each cycle.
REQ-006 SHALL have port serout  output  1  serial line; idle high.
REQ-007 SHALL have port busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port charSent  output  1  one-cycle pulse marking frame completion.

Function
REQ-009 SHALL use a 4-state FSM: IDLE, START, DATA, STOP.
REQ-010 SHALL frame each byte as: 1 start bit (0), 8 data bits MSB first, 1 stop bit (1); this matches the team's MSB-first serial-to-parallel receiver.
REQ-011 SHALL hold every bit on serout for exactly BIT_CYCLES clocks, so one frame occupies 10*BIT_CYCLES clocks.
REQ-012 SHALL accept load only in IDLE; on acceptance, capture parout into an internal 8-bit shift register, then enter START on the next edge.
REQ-013 SHALL drive serout=0 and busy=1 starting the cycle after load is accepted (latency 1 clock).
REQ-014 SHALL ignore load while busy=1; the captured byte SHALL NOT change mid-frame even if parout changes.
REQ-015 SHALL use a cycle counter of width ceil(log2(BIT_CYCLES)) that counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
REQ-016 SHALL use a 3-bit bit index in DATA; after bit index 7 completes, go to STOP; index wrap-around SHALL NOT re-enter DATA.
REQ-017 SHALL shift the internal register left by one at each DATA bit boundary; serout in DATA = register bit 7.
REQ-018 SHALL go from STOP to IDLE after BIT_CYCLES clocks; busy SHALL fall in the first IDLE cycle.
REQ-019 SHALL assert charSent for exactly one clock: the first IDLE cycle after STOP.
REQ-020 SHALL accept a load asserted in the same cycle as charSent, giving back-to-back frames with no idle gap beyond that one cycle.
REQ-021 SHALL drive serout=1 in IDLE and STOP; serout SHALL be registered (glitch-free).
REQ-022 SHALL never drive X or Z on any output after the first reset.

Reset
REQ-023 SHALL, while reset=1 at a rising edge, force state=IDLE, serout=1, busy=0, charSent=0, and clear the counters and shift register to 0.
REQ-024 SHALL abort any frame in progress on reset, with no charSent pulse; the line returns high the cycle after reset is sampled.
REQ-025 SHALL give reset priority over load in the same cycle; that load is discarded.

Verification (BIT_CYCLES=4)
REQ-026 Single byte: parout=8'hA5, load pulsed 1 clk in IDLE -> serout per 4-clk bit = 0,1,0,1,0,0,1,0,1,1; busy high 40 clks; charSent 1 clk at clk 41.
REQ-027 Load while busy: send 8'h0F; pulse load with parout=8'hFF at clk 10 -> frame still carries 0F (0,0,0,0,0,1,1,1,1,1); no second frame.
REQ-028 Back-to-back: load held high with parout=8'h00 then 8'hFF -> second start bit begins the cycle after charSent; total 81 clks; 2 charSent pulses.
REQ-029 Reset mid-frame: send 8'h3C and assert reset at clk 17 -> serout=1, busy=0 from clk 18; no charSent; next load of 8'h81 transmits correctly.
REQ-030 Reset with load: reset=1 and load=1 with parout=8'h55 in the same cycle -> stays IDLE, serout=1, busy=0.
REQ-031 Parameter corner: BIT_CYCLES=2, byte 8'h80 -> frame of 20 clks, serout = 0,1,0,0,0,0,0,0,0,1 per 2-clk bit.
